axis_rr_arbiter: RTL and testbench

//   Packet-granular round-robin arbiter that shares one AXI-stream path (the decouple

---
 rtl/axis_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: S_COUNT AXI-stream sources share one output
// through a 2-entry skid buffer; a grant is held from the first beat to the tlast beat.
module axis_rr_arbiter #(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_ENABLE = 1,
    parameter int KEEP_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [S_COUNT-1:0]             s_axis_tvalid,
    output logic [S_COUNT-1:0]             s_axis_tready,
    input  logic [S_COUNT-1:0]             s_axis_tlast,
    input  logic [S_COUNT-1:0]             s_axis_tuser,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    output logic                           grant_valid,
    output logic [$clog2(S_COUNT)-1:0]     grant_index
);
    localparam int IDX_W   = $clog2(S_COUNT);
    localparam int ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(S_COUNT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           grant_q, grant_d;
    logic [IDX_W-1:0]           rr_q, rr_d;
    logic [1:0]                 count_q, count_d;
    logic                       not_full_q, not_full_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic                       wr_ptr_q, wr_ptr_d;
    logic [1:0][ENTRY_W-1:0]    mem_q, mem_d;

    logic                       found;
    logic [IDX_W-1:0]           pick;
    logic                       g_valid;
    logic                       g_last;
    logic [DATA_WIDTH-1:0]      g_data;
    logic [KEEP_WIDTH-1:0]      g_keep;
    logic [ENTRY_W-1:0]         g_entry;
    logic                       accept;
    logic                       pop;

    // Scan requests starting at the rr pointer so priority rotates with every packet.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            if (!found && s_axis_tvalid[IDX_W'((int'(rr_q) + k) % S_COUNT)]) begin
                found = 1'b1;
                pick  = IDX_W'((int'(rr_q) + k) % S_COUNT);
            end
        end
    end

    always_comb begin
        g_valid = s_axis_tvalid[grant_q];
        g_last  = s_axis_tlast[grant_q];
        g_data  = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        g_keep  = (KEEP_ENABLE != 0) ? s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH] : '1;
        g_entry = {s_axis_tuser[grant_q], g_last, g_keep, g_data};
    end

    assign accept = (state_q == LOCKED) && not_full_q && g_valid;
    assign pop    = (count_q != 2'd0) && m_axis_tready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && g_last) begin
                    rr_d    = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready for the next cycle is precomputed from the post-update occupancy,
    // which keeps m_axis_tready out of the s_axis_tready path.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            mem_d[wr_ptr_q] = g_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d    = count_q + {1'b0, accept} - {1'b0, pop};
        not_full_d = ~count_d[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_q       <= '0;
            count_q    <= '0;
            not_full_q <= 1'b1;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            mem_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_q      <= mem_d;
        end
    end

    always_comb begin
        s_axis_tready = '0;
        if (state_q == LOCKED) begin
            s_axis_tready[grant_q] = not_full_q;
        end
    end

    assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem_q[rd_ptr_q];
    assign m_axis_tvalid = (count_q != 2'd0);
    assign grant_valid   = (state_q == LOCKED);
    assign grant_index   = grant_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: per-source packet queues feed the DUT,
// accepted beats go to a scoreboard, and a monitor checks output order and arbitration.
module tb_axis_rr_arbiter;
    localparam int S  = 4;
    localparam int DW = 32;
    localparam int KW = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          cyc;
    } obs_t;

    logic              clk;
    logic              rst;
    logic [S*DW-1:0]   s_axis_tdata;
    logic [S*KW-1:0]   s_axis_tkeep;
    logic [S-1:0]      s_axis_tvalid;
    logic [S-1:0]      s_axis_tready;
    logic [S-1:0]      s_axis_tlast;
    logic [S-1:0]      s_axis_tuser;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic              grant_valid;
    logic [1:0]        grant_index;

    logic [S-1:0]      nk_tready;
    logic [DW-1:0]     nk_tdata;
    logic [KW-1:0]     nk_tkeep;
    logic              nk_tvalid;
    logic              nk_tlast;
    logic              nk_tuser;
    logic              nk_grant_valid;
    logic [1:0]        nk_grant_index;

    beat_t srcq [S][$];
    beat_t sbq [$];
    obs_t  out_log [$];
    int    grant_log [$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          gap_pct = 0;
    int          ready_mode = 0;
    int          nk_beats = 0;
    logic [S-1:0] pause = '0;

    axis_rr_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_ENABLE(1), .KEEP_WIDTH(KW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .grant_valid(grant_valid), .grant_index(grant_index)
    );

    // Same stimulus, tkeep propagation disabled.
    axis_rr_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_ENABLE(0), .KEEP_WIDTH(KW)) dut_nk (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(nk_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(nk_tdata), .m_axis_tkeep(nk_tkeep),
        .m_axis_tvalid(nk_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(nk_tlast), .m_axis_tuser(nk_tuser),
        .grant_valid(nk_grant_valid), .grant_index(nk_grant_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic apply_stimulus(input int src, input int len, input logic [31:0] base, input logic [3:0] keep);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + 32'(k);
            b.keep = keep;
            b.last = (k == len - 1);
            b.user = 1'(k + src);
            srcq[src].push_back(b);
        end
    endtask

    // Spec rule: first requesting source scanning upward from the pointer, with wrap.
    function automatic int rr_pick(input logic [3:0] req, input int start);
        for (int k = 0; k < S; k++) begin
            if (req[(start + k) % S]) return (start + k) % S;
        end
        return -1;
    endfunction

    // Source driver: beats accepted at an edge are handed to the scoreboard.
    initial begin
        logic [S-1:0] acc;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            acc = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < S; i++) begin
                if (acc[i]) begin
                    if (srcq[i].size() > 0) sbq.push_back(srcq[i].pop_front());
                    s_axis_tvalid[i] = 1'b0;
                end
                if (srcq[i].size() == 0 || pause[i]) begin
                    s_axis_tvalid[i] = 1'b0;
                end else if (!s_axis_tvalid[i] && ($urandom_range(99) >= 32'(gap_pct))) begin
                    s_axis_tvalid[i] = 1'b1;
                end
                if (srcq[i].size() > 0) begin
                    s_axis_tdata[i*DW +: DW] = srcq[i][0].data;
                    s_axis_tkeep[i*KW +: KW] = srcq[i][0].keep;
                    s_axis_tlast[i]          = srcq[i][0].last;
                    s_axis_tuser[i]          = srcq[i][0].user;
                end
            end
            case (ready_mode)
                1:       m_axis_tready = 1'($urandom_range(1));
                2:       m_axis_tready = 1'b0;
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    // Monitor: arbitration model, handshake rules and scoreboard comparison.
    initial begin
        bit          prev_ok = 0;
        logic        prev_gv = 0;
        logic [3:0]  prev_req = 0;
        logic        prev_acc_last = 0;
        logic        prev_stall = 0;
        logic [37:0] prev_payload = 0;
        int          model_rr = 0;
        int          model_grant = 0;
        int          pending = 0;
        int          exp_g;
        beat_t       b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sbq.delete();
                model_rr   = 0;
                prev_ok    = 0;
                prev_gv    = 0;
                prev_stall = 0;
                continue;
            end
            if (prev_ok && !prev_gv) begin
                exp_g = rr_pick(prev_req, model_rr);
                if (exp_g < 0) begin
                    check_output("idle_no_grant", 64'(grant_valid), 64'd0);
                end else begin
                    check_output("grant_valid", 64'(grant_valid), 64'd1);
                    check_output("grant_index", 64'(grant_index), 64'(exp_g));
                    model_grant = exp_g;
                    pending     = (exp_g + 1) % S;
                end
            end
            if (prev_ok && prev_gv) begin
                check_output("lock_release", 64'(grant_valid), 64'(!prev_acc_last));
                if (!grant_valid) model_rr = pending;
            end
            if (grant_valid && !prev_gv) grant_log.push_back(int'(grant_index));
            if (grant_valid) begin
                check_output("locked_index", 64'(grant_index), 64'(model_grant));
                check_output("ready_only_granted", 64'(s_axis_tready & ~(4'b0001 << model_grant)), 64'd0);
            end else begin
                check_output("ready_when_idle", 64'(s_axis_tready), 64'd0);
            end
            if (prev_stall) begin
                check_output("hold_valid", 64'(m_axis_tvalid), 64'd1);
                check_output("hold_payload", 64'({m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
                             64'(prev_payload));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sbq.size() == 0) begin
                    check_output("unexpected_beat", 64'(m_axis_tdata), 64'hDEAD_0000_0000);
                end else begin
                    b = sbq.pop_front();
                    check_output("beat_data", 64'(m_axis_tdata), 64'(b.data));
                    check_output("beat_keep", 64'(m_axis_tkeep), 64'(b.keep));
                    check_output("beat_last", 64'(m_axis_tlast), 64'(b.last));
                    check_output("beat_user", 64'(m_axis_tuser), 64'(b.user));
                end
                out_log.push_back('{data: m_axis_tdata, keep: m_axis_tkeep, last: m_axis_tlast, cyc: cyc});
            end
            check_output("nk_handshake", 64'({nk_tvalid, nk_tready}), 64'({m_axis_tvalid, s_axis_tready}));
            if (nk_tvalid) check_output("nk_keep_ones", 64'(nk_tkeep), 64'hF);
            if (nk_tvalid && m_axis_tready) nk_beats++;
            prev_ok       = 1;
            prev_gv       = grant_valid;
            prev_req      = s_axis_tvalid;
            prev_acc_last = |(s_axis_tvalid & s_axis_tready & s_axis_tlast);
            prev_stall    = m_axis_tvalid && !m_axis_tready;
            prev_payload  = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < S; i++) srcq[i].delete();
        sbq.delete();
        pause      = '0;
        gap_pct    = 0;
        ready_mode = 0;
        repeat (2) @(negedge clk);
        out_log.delete();
        grant_log.delete();
        nk_beats = 0;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        bool_loop: while (n < budget) begin
            @(negedge clk);
            if (srcq[0].size() == 0 && srcq[1].size() == 0 && srcq[2].size() == 0 &&
                srcq[3].size() == 0 && sbq.size() == 0 && !m_axis_tvalid && !grant_valid)
                break;
            n++;
        end
        check_output("drain_in_budget", 64'(n < budget), 64'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        #1;
        rst = 1'b0;

        // Reset with every source requesting.
        @(negedge clk);
        for (int i = 0; i < S; i++) apply_stimulus(i, 2, 32'h100 + 32'(i * 16), 4'hF);
        repeat (5) begin
            @(negedge clk);
            check_output("reset_outputs", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                                                m_axis_tuser, grant_valid, grant_index}), 64'd0);
            check_output("reset_ready", 64'(s_axis_tready), 64'd0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_output("first_grant_valid", 64'(grant_valid), 64'd1);
        check_output("first_grant_src0", 64'(grant_index), 64'd0);
        drain(200);

        // Round robin over four 3-beat packets, plus first-beat latency.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < S; i++) apply_stimulus(i, 3, 32'hA0 + 32'(i * 16), 4'hF);
        @(negedge clk);
        check_output("lat_c0", 64'({grant_valid, m_axis_tvalid}), 64'd0);
        @(negedge clk);
        check_output("lat_c1", 64'({grant_valid, s_axis_tready, m_axis_tvalid}), 64'b1_0001_0);
        @(negedge clk);
        check_output("lat_c2_valid", 64'(m_axis_tvalid), 64'd1);
        check_output("lat_c2_data", 64'(m_axis_tdata), 64'hA0);
        drain(200);
        check_output("rr_beat_count", 64'(out_log.size()), 64'd12);
        for (int k = 0; k < out_log.size() && k < 12; k++) begin
            check_output("rr_order_data", 64'(out_log[k].data), 64'(32'hA0 + 32'(k % 3) + 32'(16 * (k / 3))));
            check_output("rr_tlast", 64'(out_log[k].last), 64'(k % 3 == 2));
            if (k % 3 != 0) check_output("rr_no_bubble", 64'(out_log[k].cyc - out_log[k-1].cyc), 64'd1);
        end

        // Fairness between two continuously streaming sources.
        do_reset();
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            apply_stimulus(1, int'($urandom_range(2, 4)), 32'h1000 + 32'(p * 16), 4'hF);
            apply_stimulus(2, int'($urandom_range(2, 4)), 32'h2000 + 32'(p * 16), 4'hF);
        end
        drain(400);
        check_output("fair_grant_count", 64'(grant_log.size()), 64'd8);
        for (int k = 0; k < grant_log.size() && k < 8; k++)
            check_output("fair_alternate", 64'(grant_log[k]), 64'((k % 2 == 0) ? 1 : 2));

        // Random backpressure on a 16-beat packet from source 3.
        do_reset();
        ready_mode = 1;
        @(negedge clk);
        apply_stimulus(3, 16, 32'h300, 4'hF);
        drain(400);
        ready_mode = 0;
        check_output("bp_beat_count", 64'(out_log.size()), 64'd16);
        for (int k = 0; k < out_log.size() && k < 16; k++)
            check_output("bp_order", 64'(out_log[k].data), 64'(32'h300 + 32'(k)));

        // Granted source stalls mid-packet while another source requests.
        do_reset();
        @(negedge clk);
        apply_stimulus(0, 8, 32'h500, 4'hF);
        apply_stimulus(1, 2, 32'h510, 4'hF);
        n = 0;
        while (srcq[0].size() > 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("stall_reached", 64'(n < 100), 64'd1);
        pause[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_output("stall_src1_blocked", 64'(s_axis_tready[1]), 64'd0);
            check_output("stall_grant_held", 64'({grant_valid, grant_index}), 64'b1_00);
        end
        pause[0] = 1'b0;
        drain(200);
        check_output("stall_grant_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2)
            check_output("stall_grant_order", 64'({grant_log[0][1:0], grant_log[1][1:0]}), 64'b00_01);

        // Reset pulse in the middle of a stalled packet.
        ready_mode = 2;
        @(negedge clk);
        apply_stimulus(2, 10, 32'h520, 4'hF);
        repeat (6) @(negedge clk);
        check_output("pre_reset_buffered", 64'(m_axis_tvalid), 64'd1);
        #1;
        rst = 1'b0;
        for (int i = 0; i < S; i++) srcq[i].delete();
        #1;
        check_output("mid_reset_outputs", 64'({m_axis_tvalid, grant_valid, s_axis_tready}), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        ready_mode = 0;
        repeat (4) begin
            @(negedge clk);
            check_output("post_reset_no_tail", 64'({m_axis_tvalid, grant_valid}), 64'd0);
        end

        // Single-beat packets with partial tkeep; the KEEP_ENABLE=0 instance must drive all-ones.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < S; i++) begin
            apply_stimulus(i, 1, 32'h600 + 32'(i), 4'h3);
            apply_stimulus(i, 1, 32'h700 + 32'(i), 4'h3);
        end
        drain(200);
        check_output("single_beat_count", 64'(out_log.size()), 64'd8);
        check_output("nk_beat_count", 64'(nk_beats), 64'd8);
        for (int k = 0; k < out_log.size() && k < 8; k++) begin
            check_output("single_last", 64'(out_log[k].last), 64'd1);
            check_output("single_keep", 64'(out_log[k].keep), 64'h3);
            check_output("single_order", 64'(out_log[k].data),
                         64'(((k < 4) ? 32'h600 : 32'h700) + 32'(k % 4)));
        end

        // Randomized mix: packet lengths, keeps, source gaps and output backpressure.
        do_reset();
        gap_pct    = 30;
        ready_mode = 1;
        @(negedge clk);
        for (int i = 0; i < S; i++) begin
            for (int p = 0; p < 6; p++)
                apply_stimulus(i, int'($urandom_range(1, 6)), $urandom, 4'($urandom_range(15)));
        end
        drain(4000);
        gap_pct    = 0;
        ready_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
